fp32_accum_seq: RTL and testbench
=================================

// Module: fp32_accum_seq
// PURPOSE
// Sequencer around the handshaked fp32 adder (in0/in1/out0 valid-ready channels). Consumes a
// stream of IEEE-754 binary32 values grouped by a last flag and feeds (running_sum, element)
// pairs to the adder. Takes each adder result back as the new running sum and emits one
// reduced sum per group. One adder operation is outstanding at any time.
// PARAMETERS
// CNT_W  16  width of the per-group element counter reported with each sum
// PORTS
// clk          in   1      clock
// rst          in   1      reset; synchronous, active-high
// in_data      in   32     fp32 element
// in_last      in   1      element is the last of its group
// in_vld       in   1      element valid
// in_rdy       out  1      element accepted when in_vld & in_rdy
// add_in0      out  32     to adder in0: running sum
// add_in0_vld  out  1      in0 valid
// add_in0_rdy  in   1      adder in0 accept (may depend combinationally on add_in0_vld)
// add_in1      out  32     to adder in1: new element
// add_in1_vld  out  1      in1 valid
// add_in1_rdy  in   1      adder in1 accept (may depend combinationally on add_in1_vld)
// add_out0     in   32     adder result
// add_out0_vld in   1      result valid
// add_out0_rdy out  1      result accepted when add_out0_vld & add_out0_rdy
// sum_out      out  32     reduced group sum
// sum_cnt      out  CNT_W  elements in the group, saturating at 2^CNT_W-1
// sum_vld      out  1      sum valid
// sum_rdy      in   1      sum accepted when sum_vld & sum_rdy
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
// - Reset: state=EMPTY. in_rdy, all *_vld and add_out0_rdy are 0. acc, x_reg, sum_out and
//   sum_cnt are 0; sent0/sent1/last_reg are cleared. A reset mid-group discards the partial sum.
//   The sequencer and the adder share rst, so no stale adder result survives reset.
// - No *_vld output depends combinationally on any *_rdy input.
// - In EMPTY: in_rdy=1. On accept: acc<=in_data and cnt<=1. The first element bypasses the
//   adder, so its bits are kept exactly, including -0 and the NaN payload.
//   Next state is EMIT if in_last, else HOLD.
// - In HOLD: in_rdy=1. On accept: x_reg<=in_data, last_reg<=in_last, sent0=sent1=0.
//   Next state is ISSUE.
// - In ISSUE: in_rdy=0. add_in0=acc, add_in1=x_reg, add_in0_vld=~sent0, add_in1_vld=~sent1.
//   Each channel's sent flag sets on its own handshake; each vld drops the cycle after its
//   handshake. Move to WAIT when both channels have handshaken, including both in the same cycle.
// - In WAIT: add_out0_rdy=1, in_rdy=0. On result: acc<=add_out0, cnt<=sat(cnt+1).
//   Next state is EMIT if last_reg, else HOLD.
// - In EMIT: sum_vld=1, sum_out=acc, sum_cnt=cnt, in_rdy=0.
//   sum_out and sum_cnt are held stable while sum_rdy=0. On sum_rdy, move to EMPTY.
// - The adder's result is taken verbatim: no rounding, NaN or inf handling here.
// - Summation is left-to-right in arrival order.
// - add_out0_vld seen outside WAIT is ignored (add_out0_rdy=0 there); this cannot occur in
//   legal operation.
// - Latency with an always-ready adder and sum_rdy=1:
//   - single-element group: sum_vld one cycle after the element is accepted;
//   - each additional element costs 4 cycles (accept, ISSUE, adder input reg, adder output
//     reg/WAIT);
//   - sustained throughput is 1 element per 4 cycles.
// - in_rdy is a registered-state decode: high only in EMPTY and HOLD.
// TESTING
// - Group {0x3F800000, 0x40000000, 0x40400000 last} -> sum_out=0x40C00000 (6.0), sum_cnt=3;
//   in_rdy low from ISSUE until the next HOLD.
// - Single element 0x80000000 with last -> sum_out=0x80000000, sum_cnt=1, one cycle after
//   accept; no adder vld ever asserted.
// - {0x7F800000, 0xFF800000 last} -> sum_out=0x7FC00000 (NaN from adder), sum_cnt=2.
// - Adder model: add_in1_rdy low 3 cycles while add_in0_rdy=1 ->
//   - add_in0_vld for exactly 1 cycle; add_in1_vld held with add_in1 stable;
//   - exactly one result consumed.
// - Hold sum_rdy=0 for 10 cycles in EMIT -> sum_out/sum_cnt stable, in_rdy=0.
//   Release -> EMPTY, and the next element is accepted.
// - Assert rst during WAIT (adder reset too) -> all outputs 0 next cycle.
//   Then {0x3FC00000 last} -> sum_out=0x3FC00000, sum_cnt=1.

Source files
------------

// File: rtl/fp32_accum_seq.sv
// Group-wise fp32 reduction sequencer driving a handshaked fp32 adder.
// Keeps one adder operation in flight and emits one sum per last-tagged group.
module fp32_accum_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [31:0]      add_in0,
    output logic             add_in0_vld,
    input  logic             add_in0_rdy,
    output logic [31:0]      add_in1,
    output logic             add_in1_vld,
    input  logic             add_in1_rdy,
    input  logic [31:0]      add_out0,
    input  logic             add_out0_vld,
    output logic             add_out0_rdy,
    output logic [31:0]      sum_out,
    output logic [CNT_W-1:0] sum_cnt,
    output logic             sum_vld,
    input  logic             sum_rdy
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_HOLD,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       x_reg_q, x_reg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_reg_q, last_reg_d;
    logic              sent0_q, sent0_d;
    logic              sent1_q, sent1_d;

    // Operands and the reported sum come straight from state, so they stay
    // stable for as long as their valid is held.
    assign add_in0 = acc_q;
    assign add_in1 = x_reg_q;
    assign sum_out = acc_q;
    assign sum_cnt = cnt_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        x_reg_d      = x_reg_q;
        cnt_d        = cnt_q;
        last_reg_d   = last_reg_q;
        sent0_d      = sent0_q;
        sent1_d      = sent1_q;
        in_rdy       = 1'b0;
        add_in0_vld  = 1'b0;
        add_in1_vld  = 1'b0;
        add_out0_rdy = 1'b0;
        sum_vld      = 1'b0;

        unique case (state_q)
            S_EMPTY: begin
                in_rdy = ~rst;
                if (in_vld && in_rdy) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? S_EMIT : S_HOLD;
                end
            end
            S_HOLD: begin
                in_rdy = ~rst;
                if (in_vld && in_rdy) begin
                    x_reg_d    = in_data;
                    last_reg_d = in_last;
                    sent0_d    = 1'b0;
                    sent1_d    = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_in0_vld = ~sent0_q;
                add_in1_vld = ~sent1_q;
                sent0_d     = sent0_q | (add_in0_vld & add_in0_rdy);
                sent1_d     = sent1_q | (add_in1_vld & add_in1_rdy);
                if (sent0_d && sent1_d) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                add_out0_rdy = 1'b1;
                if (add_out0_vld) begin
                    acc_d   = add_out0;
                    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    state_d = last_reg_q ? S_EMIT : S_HOLD;
                end
            end
            S_EMIT: begin
                sum_vld = 1'b1;
                if (sum_rdy) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            acc_q      <= '0;
            x_reg_q    <= '0;
            cnt_q      <= '0;
            last_reg_q <= 1'b0;
            sent0_q    <= 1'b0;
            sent1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            x_reg_q    <= x_reg_d;
            cnt_q      <= cnt_d;
            last_reg_q <= last_reg_d;
            sent0_q    <= sent0_d;
            sent1_q    <= sent1_d;
        end
    end

endmodule

// File: tb/tb_fp32_accum_seq.sv
// Bench for fp32_accum_seq: behavioural fp32 adder, group-sum scoreboard,
// directed scenarios and randomized groups with random back-pressure.
module tb_fp32_accum_seq;

    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [31:0]   add_in0;
    logic          add_in0_vld;
    logic          add_in0_rdy;
    logic [31:0]   add_in1;
    logic          add_in1_vld;
    logic          add_in1_rdy;
    logic [31:0]   add_out0 = '0;
    logic          add_out0_vld = 1'b0;
    logic          add_out0_rdy;
    logic [31:0]   sum_out;
    logic [CW-1:0] sum_cnt;
    logic          sum_vld;
    logic          sum_rdy = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp32_accum_seq #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
        .add_in0(add_in0), .add_in0_vld(add_in0_vld), .add_in0_rdy(add_in0_rdy),
        .add_in1(add_in1), .add_in1_vld(add_in1_vld), .add_in1_rdy(add_in1_rdy),
        .add_out0(add_out0), .add_out0_vld(add_out0_vld), .add_out0_rdy(add_out0_rdy),
        .sum_out(sum_out), .sum_cnt(sum_cnt), .sum_vld(sum_vld), .sum_rdy(sum_rdy)
    );

    // fp32 <-> double for normal numbers, zeros, infinities and NaN
    function automatic logic [63:0] f2d(input logic [31:0] f);
        int e;
        e = int'(f[30:23]);
        if (e == 0) return {f[31], 63'd0};
        if (e == 255) return {f[31], 11'h7FF, f[22:0], 29'd0};
        e = e - 127 + 1023;
        return {f[31], e[10:0], f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        int e;
        e = int'(d[62:52]);
        if (e == 0) return {d[63], 31'd0};
        if (e == 2047) return (d[51:0] != 0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
        e = e - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real r;
        r = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
        return d2f($realtobits(r));
    endfunction

    function automatic logic [31:0] itof(input int i);
        real r;
        r = real'(i);
        return d2f($realtobits(r));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Behavioural adder: one operation, result one cycle after both operands land
    logic        got0 = 1'b0, got1 = 1'b0;
    logic [31:0] op0 = '0, op1 = '0;
    logic        rdy0_en = 1'b1, rdy1_en = 1'b1;
    int          results_taken = 0;

    assign add_in0_rdy = rdy0_en & ~got0;
    assign add_in1_rdy = rdy1_en & ~got1;

    always @(posedge clk) begin
        if (rst) begin
            got0         <= 1'b0;
            got1         <= 1'b0;
            add_out0_vld <= 1'b0;
        end else begin
            if (add_in0_vld && add_in0_rdy) begin
                got0 <= 1'b1;
                op0  <= add_in0;
            end
            if (add_in1_vld && add_in1_rdy) begin
                got1 <= 1'b1;
                op1  <= add_in1;
            end
            if (got0 && got1 && !add_out0_vld) begin
                add_out0_vld <= 1'b1;
                add_out0     <= fadd(op0, op1);
            end
            if (add_out0_vld && add_out0_rdy) begin
                add_out0_vld  <= 1'b0;
                got0          <= 1'b0;
                got1          <= 1'b0;
                results_taken <= results_taken + 1;
            end
        end
    end

    // Scoreboard: left-to-right fold per group, compared on every sum handshake
    logic [31:0]   exp_q[$];
    logic [CW-1:0] expc_q[$];
    logic [31:0]   m_acc = '0;
    int            m_n = 0;
    logic          prev_hold = 1'b0;
    logic [31:0]   prev_sum = '0;
    logic [CW-1:0] prev_cnt = '0;
    logic          prev_i1_wait = 1'b0;
    logic [31:0]   prev_i1 = '0;
    int            vld0_cycles = 0;
    int            adder_vld_cycles = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            expc_q.delete();
            m_n          = 0;
            prev_hold    = 1'b0;
            prev_i1_wait = 1'b0;
        end else begin
            if (in_vld && in_rdy) begin
                m_acc = (m_n == 0) ? in_data : fadd(m_acc, in_data);
                m_n++;
                if (in_last) begin
                    exp_q.push_back(m_acc);
                    expc_q.push_back(CW'((m_n > MAXC) ? MAXC : m_n));
                    m_n = 0;
                end
            end
            if (prev_hold) begin
                check("sum_vld_held", 32'(sum_vld), 32'd1);
                check("sum_out_stable", sum_out, prev_sum);
                check("sum_cnt_stable", 32'(sum_cnt), 32'(prev_cnt));
                check("in_rdy_in_emit", 32'(in_rdy), 32'd0);
            end
            if (sum_vld && sum_rdy) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_sum");
                end else begin
                    check("sum_out", sum_out, exp_q.pop_front());
                    check("sum_cnt", 32'(sum_cnt), 32'(expc_q.pop_front()));
                end
            end
            prev_hold = sum_vld && !sum_rdy;
            prev_sum  = sum_out;
            prev_cnt  = sum_cnt;
            if (prev_i1_wait) begin
                check("add_in1_vld_held", 32'(add_in1_vld), 32'd1);
                check("add_in1_stable", add_in1, prev_i1);
            end
            prev_i1_wait = add_in1_vld && !add_in1_rdy;
            prev_i1      = add_in1;
            if (add_in0_vld) vld0_cycles++;
            if (add_in0_vld || add_in1_vld) adder_vld_cycles++;
        end
    end

    logic rand_mode = 1'b0;

    always @(negedge clk) begin
        if (rand_mode) begin
            rdy0_en = ($urandom_range(0, 2) != 0);
            rdy1_en = ($urandom_range(0, 2) != 0);
            sum_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // All directed tasks start and end at a negedge
    task automatic send(input logic [31:0] d, input logic l);
        int guard;
        guard   = 0;
        in_data = d;
        in_last = l;
        in_vld  = 1'b1;
        while (!in_rdy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_rdy) timeout("send");
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic wait_for_sum();
        int guard;
        guard = 0;
        while (!sum_vld && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!sum_vld) timeout("wait_sum");
    endtask

    task automatic wait_sum(input string name, input logic [31:0] d, input int c);
        wait_for_sum();
        check({name, "_data"}, sum_out, d);
        check({name, "_cnt"}, 32'(sum_cnt), c);
        @(negedge clk);
    endtask

    task automatic check_all_zero();
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_in0_vld", 32'(add_in0_vld), 32'd0);
        check("rst_in1_vld", 32'(add_in1_vld), 32'd0);
        check("rst_out0_rdy", 32'(add_out0_rdy), 32'd0);
        check("rst_sum_vld", 32'(sum_vld), 32'd0);
        check("rst_sum_out", sum_out, 32'd0);
        check("rst_sum_cnt", 32'(sum_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, v0, r0, guard, len, v;

        check("model_1p2", fadd(32'h3F800000, 32'h40000000), 32'h40400000);
        check("model_3p3", fadd(32'h40400000, 32'h40400000), 32'h40C00000);
        check("model_inf", fadd(32'h7F800000, 32'hFF800000), 32'h7FC00000);
        check("model_itof", itof(-3), 32'hC0400000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero();
        rst = 1'b0;
        @(negedge clk);
        check("in_rdy_idle", 32'(in_rdy), 32'd1);

        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        check("in_rdy_issue", 32'(in_rdy), 32'd0);
        send(32'h40400000, 1'b1);
        wait_sum("sum123", 32'h40C00000, 3);

        a0 = adder_vld_cycles;
        send(32'h80000000, 1'b1);
        check("single_latency", 32'(sum_vld), 32'd1);
        wait_sum("neg_zero", 32'h80000000, 1);
        check("single_no_adder", adder_vld_cycles - a0, 32'd0);

        send(32'h7F800000, 1'b0);
        send(32'hFF800000, 1'b1);
        wait_sum("inf_nan", 32'h7FC00000, 2);

        rdy1_en = 1'b0;
        v0 = vld0_cycles;
        r0 = results_taken;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        repeat (3) @(negedge clk);
        rdy1_en = 1'b1;
        wait_sum("stall_in1", 32'h40400000, 2);
        check("in0_vld_once", vld0_cycles - v0, 32'd1);
        check("one_result", results_taken - r0, 32'd1);

        sum_rdy = 1'b0;
        send(32'h40800000, 1'b1);
        wait_for_sum();
        check("emit_hold_data", sum_out, 32'h40800000);
        repeat (10) begin
            check("emit_hold_in_rdy", 32'(in_rdy), 32'd0);
            @(negedge clk);
        end
        sum_rdy = 1'b1;
        @(negedge clk);
        check("in_rdy_after_emit", 32'(in_rdy), 32'd1);
        send(32'h3F800000, 1'b1);
        wait_sum("after_emit", 32'h3F800000, 1);

        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        guard = 0;
        while (!add_out0_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!add_out0_rdy) timeout("reach_wait");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero();
        rst = 1'b0;
        @(negedge clk);
        send(32'h3FC00000, 1'b1);
        wait_sum("after_rst", 32'h3FC00000, 1);

        for (int i = 0; i < 9; i++) send(32'h3F800000, i == 8);
        wait_sum("saturate", 32'h41100000, MAXC);

        rand_mode = 1'b1;
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                v = int'($urandom_range(0, 16)) - 8;
                send(($urandom_range(0, 9) == 0) ? 32'h80000000 : itof(v), k == len - 1);
            end
        end
        rand_mode = 1'b0;
        rdy0_en   = 1'b1;
        rdy1_en   = 1'b1;
        sum_rdy   = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
